// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer.
package stream_demux_pkg;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;
  localparam int CNT_W = 16;
endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output register with valid/ready; accepts a write while draining.
module stream_demux_slot #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_last_i,
  input  logic                  rd_ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  wr_ready_o
);
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (valid_q && rd_ready_i) valid_d = 1'b0;
    // A refill in the drain cycle wins, so the slot stays full with the new beat.
    if (wr_en_i) begin
      valid_d = 1'b1;
      data_d  = wr_data_i;
      last_d  = wr_last_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign last_o     = last_q;
  assign wr_ready_o = ~valid_q | rd_ready_i;
endmodule

// File: rtl/stream_demux.sv
// Packet-aware 1:NUM_OUT stream demultiplexer; route locks for the packet duration.
// Define STREAM_DEMUX_CNT_EN to add per-output transfer counters (xfer_cnt_o).
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int NUM_OUT    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [$clog2(NUM_OUT)-1:0]           index_i,
  input  logic [DATA_WIDTH-1:0]                data_i,
  input  logic                                 last_i,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  output logic [NUM_OUT-1:0][DATA_WIDTH-1:0]   data_o,
  output logic [NUM_OUT-1:0]                   last_o,
  output logic [NUM_OUT-1:0]                   valid_o,
  input  logic [NUM_OUT-1:0]                   ready_i,
  output logic                                 locked_o,
  output logic                                 err_o
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [NUM_OUT-1:0][CNT_W-1:0]        xfer_cnt_o
`endif
);
  localparam int IDX_W = $clog2(NUM_OUT);
  localparam logic [IDX_W:0] NUM_OUT_L = (IDX_W+1)'(NUM_OUT);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, sel;
  logic               err_q, err_d;
  logic               in_range, sel_rdy, accept;
  logic [NUM_OUT-1:0] wr_en, slot_rdy;

  always_comb begin
    sel      = (state_q == LOCKED) ? idx_q : index_i;
    // The latched index was range-checked when the lock was taken.
    in_range = (state_q == LOCKED) || ({1'b0, index_i} < NUM_OUT_L);
    sel_rdy  = 1'b0;
    for (int k = 0; k < NUM_OUT; k++)
      if (sel == IDX_W'(k)) sel_rdy = slot_rdy[k];
    ready_o = ~rst_i & (~in_range | sel_rdy);
    accept  = valid_i & ready_o;
    wr_en   = '0;
    for (int k = 0; k < NUM_OUT; k++)
      if (accept && in_range && sel == IDX_W'(k)) wr_en[k] = 1'b1;
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = accept & ~in_range;
    case (state_q)
      IDLE:   if (accept && in_range && !last_i) begin
                state_d = LOCKED;
                idx_d   = index_i;
              end
      LOCKED: if (accept && last_i) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign locked_o = (state_q == LOCKED);
  assign err_o    = err_q;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    stream_demux_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_en_i    (wr_en[k]),
      .wr_data_i  (data_i),
      .wr_last_i  (last_i),
      .rd_ready_i (ready_i[k]),
      .valid_o    (valid_o[k]),
      .data_o     (data_o[k]),
      .last_o     (last_o[k]),
      .wr_ready_o (slot_rdy[k])
    );
`ifdef STREAM_DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (valid_o[k] & ready_i[k]) ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end
    assign xfer_cnt_o[k] = cnt_q;
`endif
  end
endmodule
